// File: rtl/cache.sv
// Direct-mapped one-word-per-line lookaside cache.
// Filled by snooped stores; read lookup is combinational.
module cache #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        hit,
  output logic        miss
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [31:0]      data [LINES];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic                  unused_offset;

  assign idx = addr[INDEX_BITS+1:2];
  assign tag = addr[31:INDEX_BITS+2];
  assign unused_offset = ^addr[1:0];

  always_comb begin
    hit = memread & valid[idx]
        & (tags[idx] == tag);
    miss = memread & ~hit;
    read_data = hit ? data[idx] : 32'h0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
    end else if (memwrite) begin
      valid[idx] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; valid gates them.
  always_ff @(posedge clk) begin
    if (memwrite && reset) begin
      tags[idx] <= tag;
      data[idx] <= write_data;
    end
  end

endmodule

// File: tb/tb_cache.sv
// Directed scoreboard bench for the lookaside cache.
// Expectations are queued on drive and popped on sample.
module tb_cache;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic        memread;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        hit;
  logic        miss;

  typedef struct {
    string       tag;
    logic        h;
    logic        m;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  cache #(.INDEX_BITS(4)) dut (
    .clk(clk),
    .reset(reset),
    .memwrite(memwrite),
    .memread(memread),
    .addr(addr),
    .write_data(write_data),
    .read_data(read_data),
    .hit(hit),
    .miss(miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(
    input string       t,
    input logic        h,
    input logic        m,
    input logic [31:0] d
  );
    exp_t e;
    e.tag = t;
    e.h = h;
    e.m = m;
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert ({hit, miss, read_data}
            === {e.h, e.m, e.d})
    else begin
      errors++;
      $error("FAIL %s got h=%b m=%b d=%h want h=%b m=%b d=%h",
             e.tag, hit, miss, read_data,
             e.h, e.m, e.d);
    end
  endtask

  task automatic wr(
    input logic [31:0] a,
    input logic [31:0] d
  );
    @(negedge clk);
    memread = 1'b0;
    memwrite = 1'b1;
    addr = a;
    write_data = d;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
  endtask

  task automatic rd(
    input string       t,
    input logic [31:0] a,
    input logic        h,
    input logic [31:0] d
  );
    @(negedge clk);
    memwrite = 1'b0;
    memread = 1'b1;
    addr = a;
    push(t, h, ~h, d);
    #1;
    check();
  endtask

  initial begin
    reset = 1'b0;
    memwrite = 1'b0;
    memread = 1'b1;
    addr = 32'h1004;
    write_data = '0;
    #2;
    push("in_reset", 1'b0, 1'b1, 32'h0);
    check();
    @(negedge clk);
    reset = 1'b1;

    rd("cold", 32'h1004, 1'b0, 32'h0);

    wr(32'h1004, 32'hDEADBEEF);
    rd("wr_rd", 32'h1004, 1'b1, 32'hDEADBEEF);
    rd("offset", 32'h1007, 1'b1, 32'hDEADBEEF);
    rd("oth_tag", 32'h2004, 1'b0, 32'h0);

    @(negedge clk);
    memread = 1'b0;
    addr = 32'h1004;
    push("idle", 1'b0, 1'b0, 32'h0);
    #1;
    check();

    wr(32'h1004, 32'h11111111);
    wr(32'h1044, 32'h22222222);
    rd("evicted", 32'h1004, 1'b0, 32'h0);
    rd("evictor", 32'h1044, 1'b1, 32'h22222222);

    wr(32'h1008, 32'hAAAA0000);
    @(negedge clk);
    memread = 1'b1;
    memwrite = 1'b1;
    addr = 32'h1008;
    write_data = 32'h5555FFFF;
    push("rw_old", 1'b1, 1'b0, 32'hAAAA0000);
    #1;
    check();
    @(posedge clk);
    #1;
    memwrite = 1'b0;
    push("rw_post", 1'b1, 1'b0, 32'h5555FFFF);
    check();
    rd("rw_new", 32'h1008, 1'b1, 32'h5555FFFF);

    wr(32'h1010, 32'h00000001);
    wr(32'h1010, 32'h00000002);
    rd("last_win", 32'h1010, 1'b1, 32'h00000002);

    wr(32'h2000, 32'hC0FFEE00);
    rd("mmio", 32'h2000, 1'b1, 32'hC0FFEE00);

    wr(32'h100C, 32'h12345678);
    rd("pre_rst", 32'h100C, 1'b1, 32'h12345678);
    #2;
    reset = 1'b0;
    push("async_rst", 1'b0, 1'b1, 32'h0);
    #1;
    check();
    @(negedge clk);
    reset = 1'b1;
    rd("post_rst", 32'h100C, 1'b0, 32'h0);
    rd("rst_other", 32'h1008, 1'b0, 32'h0);

    @(negedge clk);
    reset = 1'b0;
    memread = 1'b0;
    memwrite = 1'b1;
    addr = 32'h1018;
    write_data = 32'hBAD0BAD0;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    rd("wr_in_rst", 32'h1018, 1'b0, 32'h0);

    @(negedge clk);
    reset = 1'b0;
    #2;
    memread = 1'b0;
    memwrite = 1'b1;
    addr = 32'h101C;
    write_data = 32'h0BEEF001;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
    rd("rel_wr", 32'h101C, 1'b1, 32'h0BEEF001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache.md
# cache

Direct-mapped, one-word-per-line lookaside cache for the data-memory controller (`data_mem`). It snoops processor data writes to fill lines and answers reads combinationally in the same cycle they are presented. A hit lets the controller skip the block-RAM read cycle. The cache holds no dirty state; it never writes back, because the controller always performs the memory write itself.

## Interface
- `INDEX_BITS`, default 4: line index width. The cache has 2^INDEX_BITS lines (16 by default).
- `clk`, input, 1: system clock. All updates occur on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset. Low clears every valid bit immediately.
- `memwrite`, input, 1: processor store strobe for the current cycle.
- `memread`, input, 1: processor load strobe for the current cycle.
- `addr`, input, 32: byte address of the access. Bits [1:0] are ignored.
- `write_data`, input, 32: store data, written into the line as a full word.
- `read_data`, output, 32: cached word on a hit, otherwise 0. Combinational.
- `hit`, output, 1: `memread` & valid & tag match. Combinational.
- `miss`, output, 1: `memread` & ~`hit`. Combinational.

## Operation
- Address split:
  - index = `addr`[INDEX_BITS+1:2]
  - tag = `addr`[31:INDEX_BITS+2], which is 26 bits at the default
  - offset = `addr`[1:0], which is ignored
- Storage per line: valid bit, tag, 32-bit data word. The data and tag arrays need no reset; only the valid bits are reset.
- Lookup, purely combinational from the current inputs and stored state:
  - `hit` = 1 when `memread`=1, valid[index]=1, and tag[index] equals the address tag.
  - `miss` = 1 when `memread`=1 and `hit`=0.
  - When `memread`=0, both `hit` and `miss` are 0.
  - `read_data` = data[index] when `hit`=1; otherwise it is 0.
- Fill/update (write-allocate, write-through). On a rising edge with `memwrite`=1 and `reset` high:
  - data[index] <= `write_data`
  - tag[index] <= address tag
  - valid[index] <= 1
  - Any previous line at that index is replaced unconditionally (conflict eviction).
- Reads never modify state, so a read miss does not allocate.
- The write always stores the full word, whatever the access size. The controller only consults `hit` for reads.
- No address filtering: every address, including memory-mapped I/O such as 0x2000, is cached on write.
- Simultaneous `memread` and `memwrite` in the same cycle:
  - `hit`, `miss` and `read_data` reflect the state before the edge (old contents).
  - The write takes effect at the edge.
- Reset asserted (low):
  - All valid bits go to 0 asynchronously.
  - Outputs then settle to `hit`=0, `miss`=`memread`, `read_data`=0.
  - Writes are ignored while reset is low.
- Reset released mid-stream: the first rising edge with `reset` high performs any pending write normally.

## Timing
- Lookup latency: 0 cycles, combinational from `addr`/`memread` to `hit`/`miss`/`read_data`.
  - The controller samples these at the same edge it registers the request, so the path must close within one clock.
- Write latency: 1 edge. A read of the same address in the following cycle hits and returns the new data.
- No handshake, no stall output; the cache never blocks.
- Reset values: all valid = 0, so `hit`=0 and `read_data`=0 regardless of `addr`.
- Back-to-back writes to the same index are allowed; the last write wins.

## Test plan
- **Cold read.** Reset low then high; `memread`=1, `addr`=0x1004. Required: `hit`=0, `miss`=1, `read_data`=0.
- **Write then read.**
  - Edge with `memwrite`=1, `addr`=0x1004, `write_data`=0xDEADBEEF.
  - Next cycle `memread`=1, `addr`=0x1004: `hit`=1, `miss`=0, `read_data`=0xDEADBEEF.
  - The same read with `addr`=0x1007 (offset ignored) also hits.
- **Conflict eviction.**
  - Write 0x11111111 to 0x1004, then write 0x22222222 to 0x1044 (same index 1, different tag).
  - Read 0x1004: miss, `read_data`=0.
  - Read 0x1044: hit, `read_data`=0x22222222.
- **Read/write same cycle.**
  - Line at 0x1008 holds 0xAAAA0000.
  - Assert `memread`=1 and `memwrite`=1 at 0x1008 with `write_data`=0x5555FFFF. Before the edge: `read_data`=0xAAAA0000.
  - Next cycle read: 0x5555FFFF.
- **Async reset.**
  - With a valid line at 0x100C and `memread`=1, drive `reset` low between clock edges.
  - `hit` must drop to 0 and `miss` rise to 1 without waiting for a clock edge.
  - After release, the line stays invalid.
- **Idle outputs.** With `memread`=0 over any valid address: `hit`=0, `miss`=0, `read_data`=0.
